// File: rtl/sobel_window_engine.sv
// sobel_window_engine
//   Builds a sliding 3x3 window from the three line-buffer row taps and emits
//   the Sobel gradient magnitude |Gx|+|Gy|, saturated to 8 bits, for every
//   interior pixel. Two pipeline stages follow the window: A registers |Gx|
//   and |Gy|, B sums, saturates and thresholds.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   valid_i       a new pixel column is on data0_i..data2_i
//   row_ok_i      all three taps are valid; a column is accepted only with valid_i
//   data0_i       bottom row tap (newest line)
//   data1_i       middle row tap
//   data2_i       top row tap (oldest line)
//   pix_o         saturated gradient magnitude
//   edge_o        pix_o > THRESH
//   valid_o       pix_o / edge_o valid this cycle
//   frame_done_o  pulses with the last valid_o of a frame
module sobel_window_engine #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter logic [7:0]  THRESH     = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic       row_ok_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  input  logic [7:0] data2_i,
  output logic [7:0] pix_o,
  output logic       edge_o,
  output logic       valid_o,
  output logic       frame_done_o
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  // The row counter counts output lines only, hence HEIGHT-3 as its top value.
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 3);

  // a + 2b + c with no overflow (max 1020).
  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return 10'(a) + {1'b0, b, 1'b0} + 10'(c);
  endfunction

  function automatic logic [9:0] absv(input logic signed [10:0] d);
    return 10'(d[10] ? -d : d);
  endfunction

  // Window columns: w2 left/oldest, w0 right/newest. Element [0]=top, [2]=bottom.
  logic [2:0][7:0] r_w0, r_w1, r_w2;
  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;
  logic            r_win_vld, r_win_last;
  logic [9:0]      r_gx_abs, r_gy_abs;
  logic            r_a_vld, r_a_last;
  logic [7:0]      r_pix;
  logic            r_edge, r_vld, r_last;

  logic                w_accept, w_last;
  logic [9:0]          w_sum_l, w_sum_r, w_sum_t, w_sum_b;
  logic signed [10:0]  w_gx, w_gy;
  logic [10:0]         w_mag;
  logic [7:0]          w_pix;

  always_comb begin
    w_accept = valid_i & row_ok_i;
    w_last   = (r_col == ColLast) && (r_row == RowLast);

    w_sum_l = wsum(r_w2[0], r_w2[1], r_w2[2]);
    w_sum_r = wsum(r_w0[0], r_w0[1], r_w0[2]);
    w_sum_t = wsum(r_w2[0], r_w1[0], r_w0[0]);
    w_sum_b = wsum(r_w2[2], r_w1[2], r_w0[2]);
    w_gx    = $signed({1'b0, w_sum_r}) - $signed({1'b0, w_sum_l});
    w_gy    = $signed({1'b0, w_sum_t}) - $signed({1'b0, w_sum_b});

    w_mag = {1'b0, r_gx_abs} + {1'b0, r_gy_abs};
    w_pix = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];
  end

  // Window and position counters move only on accepted columns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w0       <= '0;
      r_w1       <= '0;
      r_w2       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
    end else begin
      // Window flag is a one-cycle tag; it must drop when nothing is accepted.
      r_win_vld  <= w_accept && (r_col >= ColW'(2));
      r_win_last <= w_accept && w_last;
      if (w_accept) begin
        r_w2 <= r_w1;
        r_w1 <= r_w0;
        r_w0 <= {data0_i, data1_i, data2_i};
        if (r_col == ColLast) begin
          r_col <= '0;
          r_row <= (r_row == RowLast) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Pipeline advances every cycle regardless of valid_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gx_abs <= '0;
      r_gy_abs <= '0;
      r_a_vld  <= 1'b0;
      r_a_last <= 1'b0;
      r_pix    <= '0;
      r_edge   <= 1'b0;
      r_vld    <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_gx_abs <= absv(w_gx);
      r_gy_abs <= absv(w_gy);
      r_a_vld  <= r_win_vld;
      r_a_last <= r_win_last;
      r_pix    <= w_pix;
      r_edge   <= w_pix > THRESH;
      r_vld    <= r_a_vld;
      r_last   <= r_a_last;
    end
  end

  assign pix_o        = r_pix;
  assign edge_o       = r_edge;
  assign valid_o      = r_vld;
  assign frame_done_o = r_last;

endmodule

// File: tb/tb_sobel_window_engine.sv
// Bench for sobel_window_engine: two instances (8x5 and 4x4) share one input
// stream; a frame-level reference model predicts every output and its cycle.
module tb_sobel_window_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i, row_ok_i;
  logic [7:0] data0_i, data1_i, data2_i;
  logic [7:0] pix8, pix4;
  logic       edge8, edge4, vld8, vld4, fd8, fd4;

  always #5 clk = ~clk;

  sobel_window_engine #(.IMG_WIDTH(8), .IMG_HEIGHT(5), .THRESH(8'd128)) u_dut8 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .row_ok_i(row_ok_i),
    .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i),
    .pix_o(pix8), .edge_o(edge8), .valid_o(vld8), .frame_done_o(fd8)
  );

  sobel_window_engine #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .THRESH(8'd128)) u_dut4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .row_ok_i(row_ok_i),
    .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i),
    .pix_o(pix4), .edge_o(edge4), .valid_o(vld4), .frame_done_o(fd4)
  );

  typedef struct {int due; int pix; bit edg; bit last;} exp_t;
  typedef struct {logic [23:0] left, mid, right; logic [7:0] pix; logic edg;} vec_t;

  exp_t        q8[$];
  exp_t        q4[$];
  vec_t        tbl[10];
  int          total = 0, bad = 0, cyc = 0;
  int          acc_n[2];
  logic [23:0] hist[2][3];
  int          nvalid[2], nfd[2], fd_at[2], noff[2];
  int          target;
  logic [17:0] pat, want;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      acc_n[k] = 0;
      for (int c = 0; c < 3; c++) hist[k][c] = '0;
    end
    q8.delete();
    q4.delete();
  endtask

  task automatic stats_clear();
    for (int k = 0; k < 2; k++) begin
      nvalid[k] = 0; nfd[k] = 0; fd_at[k] = 0; noff[k] = 0;
    end
  endtask

  // Frame position comes from the count of accepted columns; the window is
  // simply the last three accepted columns.
  task automatic model_accept(input int k);
    int w, h, p, col, gx, gy, mag, pix;
    int g[3][3];
    exp_t e;
    w = (k == 0) ? 8 : 4;
    h = (k == 0) ? 5 : 4;
    p = acc_n[k] % (w * (h - 2));
    col = p % w;
    hist[k][0] = hist[k][1];
    hist[k][1] = hist[k][2];
    hist[k][2] = {data2_i, data1_i, data0_i};
    acc_n[k]++;
    if (col >= 2) begin
      for (int c = 0; c < 3; c++) begin
        g[0][c] = int'(hist[k][c][23:16]);
        g[1][c] = int'(hist[k][c][15:8]);
        g[2][c] = int'(hist[k][c][7:0]);
      end
      gx  = (g[0][2] + 2 * g[1][2] + g[2][2]) - (g[0][0] + 2 * g[1][0] + g[2][0]);
      gy  = (g[0][0] + 2 * g[0][1] + g[0][2]) - (g[2][0] + 2 * g[2][1] + g[2][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      pix = (mag > 255) ? 255 : mag;
      e.due  = cyc + 2;
      e.pix  = pix;
      e.edg  = pix > 128;
      e.last = (p == w * (h - 2) - 1);
      if (k == 0) q8.push_back(e);
      else q4.push_back(e);
    end
  endtask

  task automatic check_dut(input int k);
    logic v, f, eg;
    logic [7:0] p;
    exp_t e;
    bit have;
    e = '{0, 0, 1'b0, 1'b0};
    if (k == 0) begin
      v = vld8; f = fd8; eg = edge8; p = pix8;
      have = (q8.size() > 0) && (q8[0].due == cyc);
      if (have) e = q8.pop_front();
    end else begin
      v = vld4; f = fd4; eg = edge4; p = pix4;
      have = (q4.size() > 0) && (q4[0].due == cyc);
      if (have) e = q4.pop_front();
    end
    if (have)
      chk(k == 0 ? "out8" : "out4", v && p == 8'(e.pix) && eg == e.edg && f == e.last,
          {v, p, eg, f}, {1'b1, 8'(e.pix), e.edg, e.last});
    else
      chk(k == 0 ? "idle8" : "idle4", !v && !f, {v, f}, 0);
    if (v) begin
      nvalid[k]++;
      if (p != 8'(target)) noff[k]++;
    end
    if (f) begin
      nfd[k]++;
      fd_at[k] = nvalid[k];
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst && valid_i && row_ok_i) begin
      model_accept(0);
      model_accept(1);
    end
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic feed(input logic v, input logic ok, input logic [23:0] c);
    valid_i  = v;
    row_ok_i = ok;
    data2_i  = c[23:16];
    data1_i  = c[15:8];
    data0_i  = c[7:0];
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    valid_i = 1'b0;
    row_ok_i = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{24'h4d4d4d, 24'h4d4d4d, 24'h4d4d4d, 8'd0,   1'b0}; // flat
    tbl[1] = '{24'h000000, 24'h000000, 24'h323232, 8'd200, 1'b1}; // vertical step 50
    tbl[2] = '{24'h000000, 24'h000000, 24'h646464, 8'd255, 1'b1}; // saturates
    tbl[3] = '{24'h0a0a00, 24'h0a0a00, 24'h0a0a00, 8'd40,  1'b0}; // horizontal step
    tbl[4] = '{24'h000000, 24'h000000, 24'h202020, 8'd128, 1'b0}; // equal to THRESH
    tbl[5] = '{24'h000000, 24'h000000, 24'h014000, 8'd130, 1'b1}; // just above
    tbl[6] = '{24'h323232, 24'h000000, 24'h000000, 8'd200, 1'b1}; // negative Gx
    tbl[7] = '{24'h000032, 24'h000032, 24'h000032, 8'd200, 1'b1}; // negative Gy
    tbl[8] = '{24'hffff00, 24'hffff00, 24'hffff00, 8'd255, 1'b1}; // Gy max
    tbl[9] = '{24'h0a141e, 24'h28323c, 24'h0c0c0c, 8'd92,  1'b0}; // mixed signs

    data0_i = '0; data1_i = '0; data2_i = '0;
    target = 0;
    stats_clear();
    do_reset();
    chk("reset8", {vld8, pix8, edge8, fd8} == 0, {vld8, pix8, edge8, fd8}, 0);
    chk("reset4", {vld4, pix4, edge4, fd4} == 0, {vld4, pix4, edge4, fd4}, 0);

    // Single-window vectors: columns 0,1,2 of a line, result two edges later.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      feed(1'b1, 1'b1, tbl[i].left);
      feed(1'b1, 1'b1, tbl[i].mid);
      feed(1'b1, 1'b1, tbl[i].right);
      feed(1'b0, 1'b1, 24'h0);
      feed(1'b0, 1'b1, 24'h0);
      chk($sformatf("vec%0d", i), vld4 && pix4 == tbl[i].pix && edge4 == tbl[i].edg,
          {vld4, pix4, edge4}, {1'b1, tbl[i].pix, tbl[i].edg});
    end

    // Flat frame on the 8x5 instance.
    do_reset();
    stats_clear();
    target = 0;
    repeat (24) feed(1'b1, 1'b1, 24'h4d4d4d);
    repeat (3) feed(1'b0, 1'b1, 24'h0);
    chk("flat_count", nvalid[0] == 18, nvalid[0], 18);
    chk("flat_done", nfd[0] == 1 && fd_at[0] == 18, {nfd[0], fd_at[0]}, {32'd1, 32'd18});
    chk("flat_pix", noff[0] == 0, noff[0], 0);

    // Horizontal step everywhere.
    do_reset();
    stats_clear();
    target = 40;
    repeat (24) feed(1'b1, 1'b1, 24'h0a0a00);
    repeat (3) feed(1'b0, 1'b1, 24'h0);
    chk("hstep_pix8", noff[0] == 0 && nvalid[0] == 18, {noff[0], nvalid[0]}, 18);
    chk("hstep_pix4", noff[1] == 0 && nvalid[1] == 12, {noff[1], nvalid[1]}, 12);

    // Line boundaries on the 4x4 instance, two back-to-back frames.
    do_reset();
    stats_clear();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) feed(1'b1, 1'b1, 24'($urandom()));
      else feed(1'b0, 1'b1, 24'h0);
      pat[i]  = vld4;
      want[i] = (i >= 2) && (((i - 2) % 4) >= 2);
    end
    chk("line_pattern", pat == want, pat, want);
    chk("line_counts", nvalid[1] == 8 && nfd[1] == 2, {nvalid[1], nfd[1]}, {32'd8, 32'd2});

    // row_ok gating followed by random valid gaps and row_ok drops.
    do_reset();
    stats_clear();
    for (int i = 0; i < 16; i++) feed(1'($urandom_range(0, 1)), 1'b0, 24'($urandom()));
    repeat (2) feed(1'b0, 1'b1, 24'h0);
    chk("rowok_gate", nvalid[0] == 0 && nvalid[1] == 0, {nvalid[0], nvalid[1]}, 0);
    for (int i = 0; i < 300; i++)
      feed(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0), 24'($urandom()));
    repeat (3) feed(1'b0, 1'b1, 24'h0);
    chk("drain", q8.size() == 0 && q4.size() == 0, {q8.size(), q4.size()}, 0);

    // Asynchronous reset mid-frame.
    do_reset();
    stats_clear();
    for (int i = 0; i < 100 && nvalid[0] < 10; i++) feed(1'b1, 1'b1, 24'($urandom()));
    chk("reach10", nvalid[0] == 10, nvalid[0], 10);
    valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst8", !vld8 && pix8 == 0 && !fd8, {vld8, pix8, fd8}, 0);
    chk("async_rst4", !vld4 && pix4 == 0 && !fd4, {vld4, pix4, fd4}, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    stats_clear();
    repeat (24) feed(1'b1, 1'b1, 24'($urandom()));
    repeat (3) feed(1'b0, 1'b1, 24'h0);
    chk("post_rst_count", nvalid[0] == 18 && nfd[0] == 1 && fd_at[0] == 18,
        {nvalid[0], nfd[0]}, {32'd18, 32'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
